majority_vote_ctrl: RTL and testbench
=====================================

# majority_vote_ctrl

Round-based vote collection controller that sequences the team's 5-input majority function. Five voters each deliver one vote per round through a valid strobe. The controller latches each voter's first vote, closes the round when all five have voted (or on timeout), and presents the majority decision through a valid/ready handshake. It sits between the voter sources and the downstream consumer of the decision, and contains its own majority evaluation over the latched votes.

## Interface
- TIMEOUT_CYCLES, 16, maximum COLLECT-state duration in cycles; legal range 1..65535. Only meaningful when the timeout feature is compiled in.
- clk  in  1  sole clock; all logic rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  opens a round; honoured only in IDLE.
- vote_valid  in  5  bit i: voter i presents a vote this cycle.
- vote_val  in  5  bit i: voter i's vote value, qualified by vote_valid[i].
- result_ready  in  1  consumer accepts result.
- busy  out  1  high whenever state is not IDLE.
- result_valid  out  1  high in DONE.
- result  out  1  majority decision.
- vote_count  out  3  number of voters whose votes are latched this round (0..5).
- voted_mask  out  5  bit i set once voter i's vote is latched.
- timed_out  out  1  round closed by timeout rather than completion.

## Operation
- States: IDLE, COLLECT, DONE. Reset enters IDLE.
- Reset values: busy=0, result_valid=0, result=0, vote_count=0, voted_mask=0, timed_out=0. The latched vote register and timer are 0.
- IDLE -> COLLECT when start=1. On this transition, clear voted_mask, the vote register, timed_out, and the timer.
- COLLECT: on each edge, for every i with vote_valid[i]=1 and voted_mask[i]=0, latch vote_val[i] and set voted_mask[i].
  - First vote wins. Later vote_valid[i] from an already-voted voter is ignored.
  - Votes from several voters in the same cycle are all captured.
- COLLECT -> DONE when the next voted_mask equals 5'b11111 (completion).
- DONE: result_valid=1. All outputs hold until result_ready=1, then DONE -> IDLE. The registers keep their values until the next start.
- start outside IDLE is ignored. vote_valid outside COLLECT is ignored.
- result = 1 iff the popcount of (votes AND voted_mask) is at least 3. Missing votes count as 0.
- vote_count = popcount(voted_mask).
- All outputs are functions of registered state only. There is no combinational path from inputs to outputs.
- rst_n=0 in any state: on that edge, all state and outputs return to their reset values. Any round in progress is discarded.

## Timing
- start sampled at edge E0: busy=1 and state COLLECT after E0.
- Completing vote sampled at edge Ek: result_valid=1 after Ek, so latency is 0 cycles beyond the capturing edge. If all five votes arrive in the first COLLECT cycle, result_valid is high after E1.
- Timeout (when compiled in): the timer increments every COLLECT cycle. At the edge where timer == TIMEOUT_CYCLES-1:
  - the state goes to DONE with timed_out=1;
  - votes present at that edge are still captured.
  - COLLECT therefore lasts at most TIMEOUT_CYCLES cycles.
- Completion and timeout on the same edge: completion wins, timed_out=0.
- Handshake: the result transfers on an edge with result_valid=1 and result_ready=1. result_valid=0 after that edge. A new start is honoured on the following edge at the earliest.
- result_ready while not in DONE has no effect.

## Configuration
- Macro: MAJORITY_VOTE_TIMEOUT_EN.
- Defined: the timer and timeout behaviour above are present. timed_out can assert.
- Undefined: no timer is built. COLLECT exits only on completion, with no bound on its duration. timed_out is tied to 0. TIMEOUT_CYCLES is unused.

## Test plan
- Reset, then start; in the first COLLECT cycle drive vote_valid=11111, vote_val=11111 -> result_valid=1 after that edge, result=1, vote_count=5, timed_out=0.
- Drive votes (voter0..voter4) = 1,0,0,1,0, one voter per cycle -> result_valid on the fifth vote's edge, result=0, voted_mask=11111.
- Drive votes 1,1,0,1,1 two per cycle, with the final single vote last -> result=1.
- Timeout (macro defined, TIMEOUT_CYCLES=16): only voters 0, 1 and 3 vote 1 -> result_valid exactly 16 cycles after entering COLLECT, result=1, vote_count=3, timed_out=1, voted_mask=01011.
- Duplicate vote: voter0 votes 1, later votes 0, the other voters vote 0,1,1,0 -> voter0's 1 is kept, result=1. A second start pulse during COLLECT does not clear voted_mask.
- Backpressure and reset: hold result_ready=0 for 5 cycles in DONE -> outputs stable, start ignored. Then result_ready=1 -> IDLE next edge. Separately, assert rst_n=0 mid-COLLECT -> all outputs zero after that edge.

Source files
------------

// File: rtl/majority_vote_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : majority_vote_ctrl
//  Purpose  : Round-based collector for five voters. It latches each voter's
//             first vote and closes the round when all five have voted (or,
//             optionally, on timeout). It then presents the 5-input majority
//             decision on a valid/ready handshake.
//  Options  : MAJORITY_VOTE_TIMEOUT_EN - when defined, a COLLECT-state timer
//             closes the round after TIMEOUT_CYCLES cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module majority_vote_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic [4:0] vote_valid_i,
   input  logic [4:0] vote_val_i,
   input  logic       result_ready_i,
   output logic       busy_o,
   output logic       result_valid_o,
   output logic       result_o,
   output logic [2:0] vote_count_o,
   output logic [4:0] voted_mask_o,
   output logic       timed_out_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [4:0] mask_q,  mask_d;
   logic [4:0] votes_q, votes_d;
   logic [4:0] new_votes;

`ifdef MAJORITY_VOTE_TIMEOUT_EN
   // Last timer value of a round; the round closes on the edge that sees it.
   localparam logic [15:0] C_TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] timer_q, timer_d;
   logic        timed_out_q, timed_out_d;
`endif

   // Number of set bits in a 5-bit vector.
   function automatic logic [2:0] popcount5(input logic [4:0] v);
      logic [2:0] cnt;
      cnt = 3'd0;
      for (int i = 0; i < 5; i++) begin
         cnt = cnt + {2'b00, v[i]};
      end
      return cnt;
   endfunction

   // Voters offering a vote this cycle that have not voted yet this round.
   assign new_votes = vote_valid_i & ~mask_q;

   // Next-state logic: round sequencing, first-vote-wins capture and timeout.
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      votes_d = votes_q;
`ifdef MAJORITY_VOTE_TIMEOUT_EN
      timer_d     = timer_q;
      timed_out_d = timed_out_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_COLLECT;
               mask_d  = 5'b00000;
               votes_d = 5'b00000;
`ifdef MAJORITY_VOTE_TIMEOUT_EN
               timer_d     = 16'd0;
               timed_out_d = 1'b0;
`endif
            end
         end
         ST_COLLECT: begin
            mask_d  = mask_q | new_votes;
            votes_d = (votes_q & ~new_votes) | (vote_val_i & new_votes);
            if (&mask_d) begin
               // Completion takes priority over a coincident timeout.
               state_d = ST_DONE;
            end
`ifdef MAJORITY_VOTE_TIMEOUT_EN
            else if (timer_q == C_TIMER_LAST) begin
               state_d     = ST_DONE;
               timed_out_d = 1'b1;
            end else begin
               timer_d = timer_q + 16'd1;
            end
`endif
         end
         ST_DONE: begin
            if (result_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and round registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mask_q  <= 5'b00000;
         votes_q <= 5'b00000;
`ifdef MAJORITY_VOTE_TIMEOUT_EN
         timer_q     <= 16'd0;
         timed_out_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         votes_q <= votes_d;
`ifdef MAJORITY_VOTE_TIMEOUT_EN
         timer_q     <= timer_d;
         timed_out_q <= timed_out_d;
`endif
      end
   end

   // Outputs decode registered state only; unvoted voters count as 0.
   assign busy_o         = (state_q != ST_IDLE);
   assign result_valid_o = (state_q == ST_DONE);
   assign result_o       = (popcount5(votes_q & mask_q) >= 3'd3);
   assign vote_count_o   = popcount5(mask_q);
   assign voted_mask_o   = mask_q;
`ifdef MAJORITY_VOTE_TIMEOUT_EN
   assign timed_out_o    = timed_out_q;
`else
   assign timed_out_o    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_majority_vote_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_majority_vote_ctrl
//  Purpose  : Self-checking bench for majority_vote_ctrl: directed rounds
//             followed by randomized traffic against a round-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_majority_vote_ctrl;

   localparam int TMO = 16;
   localparam int P_IDLE = 0, P_COLLECT = 1, P_DONE = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [4:0] vote_valid = 5'b0;
   logic [4:0] vote_val = 5'b0;
   logic       result_ready = 1'b0;
   logic       busy, result_valid, result, timed_out;
   logic [2:0] vote_count;
   logic [4:0] voted_mask;

   int checks = 0;
   int failures = 0;

   // Model: round phase, which voters have voted, and their first vote.
   int phase = P_IDLE;
   bit m_got[5];
   bit m_vote[5];
   bit m_to;
   int m_cycles;

   majority_vote_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start_i        (start),
      .vote_valid_i   (vote_valid),
      .vote_val_i     (vote_val),
      .result_ready_i (result_ready),
      .busy_o         (busy),
      .result_valid_o (result_valid),
      .result_o       (result),
      .vote_count_o   (vote_count),
      .voted_mask_o   (voted_mask),
      .timed_out_o    (timed_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int n_latched();
      int n = 0;
      for (int i = 0; i < 5; i++) if (m_got[i]) n++;
      return n;
   endfunction

   function automatic int n_yes();
      int n = 0;
      for (int i = 0; i < 5; i++) if (m_got[i] && m_vote[i]) n++;
      return n;
   endfunction

   function automatic logic [4:0] m_mask();
      logic [4:0] m = 5'b0;
      for (int i = 0; i < 5; i++) m[i] = m_got[i];
      return m;
   endfunction

   // Apply one clock edge's worth of inputs to the round model.
   task automatic model_edge();
      if (!rst_n) begin
         phase = P_IDLE;
         m_to = 0;
         m_cycles = 0;
         for (int i = 0; i < 5; i++) begin m_got[i] = 0; m_vote[i] = 0; end
      end else if (phase == P_IDLE) begin
         if (start) begin
            phase = P_COLLECT;
            m_to = 0;
            m_cycles = 0;
            for (int i = 0; i < 5; i++) begin m_got[i] = 0; m_vote[i] = 0; end
         end
      end else if (phase == P_COLLECT) begin
         m_cycles++;
         for (int i = 0; i < 5; i++) begin
            if (vote_valid[i] && !m_got[i]) begin
               m_got[i] = 1;
               m_vote[i] = vote_val[i];
            end
         end
         if (n_latched() == 5) phase = P_DONE;
`ifdef MAJORITY_VOTE_TIMEOUT_EN
         else if (m_cycles == TMO) begin
            phase = P_DONE;
            m_to = 1;
         end
`endif
      end else begin
         if (result_ready) phase = P_IDLE;
      end
   endtask

   task automatic check_all();
      check("busy",         {7'b0, busy},         {7'b0, phase != P_IDLE});
      check("result_valid", {7'b0, result_valid}, {7'b0, phase == P_DONE});
      check("result",       {7'b0, result},       {7'b0, n_yes() >= 3});
      check("vote_count",   {5'b0, vote_count},   8'(n_latched()));
      check("voted_mask",   {3'b0, voted_mask},   {3'b0, m_mask()});
      check("timed_out",    {7'b0, timed_out},    {7'b0, m_to});
   endtask

   // Drive inputs (at the falling edge), take one rising edge, then check.
   task automatic step(input logic s, input logic [4:0] vv, input logic [4:0] vval,
                       input logic rdy, input logic rn);
      start = s; vote_valid = vv; vote_val = vval; result_ready = rdy; rst_n = rn;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      @(negedge clk);
   endtask

   task automatic idle_step();
      step(1'b0, 5'b0, 5'b0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [4:0] held_mask;
      @(negedge clk);

      // Reset
      step(1'b0, 5'b11111, 5'b11111, 1'b0, 1'b0);
      step(1'b0, 5'b0, 5'b0, 1'b0, 1'b0);
      check("reset_busy", {7'b0, busy}, 8'd0);
      check("reset_mask", {3'b0, voted_mask}, 8'd0);

      // All five votes in the first COLLECT cycle
      step(1'b1, 5'b0, 5'b0, 1'b0, 1'b1);
      check("start_busy", {7'b0, busy}, 8'd1);
      step(1'b0, 5'b11111, 5'b11111, 1'b0, 1'b1);
      check("all5_valid", {7'b0, result_valid}, 8'd1);
      check("all5_result", {7'b0, result}, 8'd1);
      check("all5_count", {5'b0, vote_count}, 8'd5);
      step(1'b0, 5'b0, 5'b0, 1'b1, 1'b1);

      // One voter per cycle: 1,0,0,1,0
      step(1'b1, 5'b0, 5'b0, 1'b0, 1'b1);
      step(1'b0, 5'b00001, 5'b00001, 1'b0, 1'b1);
      step(1'b0, 5'b00010, 5'b00000, 1'b0, 1'b1);
      step(1'b0, 5'b00100, 5'b00000, 1'b0, 1'b1);
      step(1'b0, 5'b01000, 5'b01000, 1'b0, 1'b1);
      check("seq_not_done", {7'b0, result_valid}, 8'd0);
      step(1'b0, 5'b10000, 5'b00000, 1'b0, 1'b1);
      check("seq_valid", {7'b0, result_valid}, 8'd1);
      check("seq_result", {7'b0, result}, 8'd0);
      check("seq_mask", {3'b0, voted_mask}, 8'h1f);
      step(1'b0, 5'b0, 5'b0, 1'b1, 1'b1);

      // Two per cycle: 1,1,0,1,1
      step(1'b1, 5'b0, 5'b0, 1'b0, 1'b1);
      step(1'b0, 5'b00011, 5'b00011, 1'b0, 1'b1);
      step(1'b0, 5'b01100, 5'b01000, 1'b0, 1'b1);
      step(1'b0, 5'b10000, 5'b10000, 1'b0, 1'b1);
      check("pair_result", {7'b0, result}, 8'd1);
      step(1'b0, 5'b0, 5'b0, 1'b1, 1'b1);

      // Duplicate vote and start during COLLECT
      step(1'b1, 5'b0, 5'b0, 1'b0, 1'b1);
      step(1'b0, 5'b00001, 5'b00001, 1'b0, 1'b1);
      step(1'b1, 5'b00001, 5'b00000, 1'b0, 1'b1);
      check("dup_mask", {3'b0, voted_mask}, 8'h01);
      step(1'b0, 5'b11110, 5'b01100, 1'b0, 1'b1);
      check("dup_result", {7'b0, result}, 8'd1);

      // Backpressure in DONE: outputs hold, start and votes ignored
      held_mask = voted_mask;
      for (int k = 0; k < 5; k++) step(1'b1, 5'($urandom), 5'($urandom), 1'b0, 1'b1);
      check("bp_valid", {7'b0, result_valid}, 8'd1);
      check("bp_mask", {3'b0, voted_mask}, {3'b0, held_mask});
      step(1'b0, 5'b0, 5'b0, 1'b1, 1'b1);
      check("bp_release", {7'b0, busy}, 8'd0);

      // Reset mid-COLLECT
      step(1'b1, 5'b0, 5'b0, 1'b0, 1'b1);
      step(1'b0, 5'b00101, 5'b00101, 1'b0, 1'b1);
      step(1'b0, 5'b00010, 5'b00010, 1'b0, 1'b0);
      check("rst_mid_count", {5'b0, vote_count}, 8'd0);
      check("rst_mid_busy", {7'b0, busy}, 8'd0);

      // Partial round: voters 0,1,3 vote 1
      step(1'b1, 5'b0, 5'b0, 1'b0, 1'b1);
      step(1'b0, 5'b01011, 5'b01011, 1'b0, 1'b1);
      for (int k = 2; k < TMO; k++) idle_step();
      check("partial_pending", {7'b0, result_valid}, 8'd0);
      idle_step();
`ifdef MAJORITY_VOTE_TIMEOUT_EN
      check("tmo_valid", {7'b0, result_valid}, 8'd1);
      check("tmo_flag", {7'b0, timed_out}, 8'd1);
      check("tmo_mask", {3'b0, voted_mask}, 8'h0b);
      check("tmo_count", {5'b0, vote_count}, 8'd3);
      check("tmo_result", {7'b0, result}, 8'd1);
`else
      for (int k = 0; k < 20; k++) idle_step();
      check("notmo_valid", {7'b0, result_valid}, 8'd0);
      check("notmo_busy", {7'b0, busy}, 8'd1);
      step(1'b0, 5'b10100, 5'b00000, 1'b0, 1'b1);
      check("notmo_done", {7'b0, result_valid}, 8'd1);
`endif
      step(1'b0, 5'b0, 5'b0, 1'b1, 1'b1);

      // Randomized traffic
      for (int k = 0; k < 2000; k++) begin
         step(($urandom_range(0, 3) == 0),
              5'($urandom) & 5'($urandom),
              5'($urandom),
              ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 99) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
